// File: rtl/sd_cmd_engine.sv
// SD-card SPI-mode command sequencer: frames a 6-byte command, polls R1 and optionally
// reads one 512-byte data block through the SPI byte host's wr/dsr handshake.
module sd_cmd_engine #(
  parameter int NCR_MAX = 8,
  parameter int TOK_MAX = 4095,
  parameter int WR_GAP  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic        read_block,
  output logic        busy,
  output logic        done,
  output logic [7:0]  r1,
  output logic        err_timeout,
  output logic        err_token,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        cs_n,
  output logic [7:0]  spi_di,
  output logic        spi_wr,
  input  logic [7:0]  spi_do,
  input  logic        spi_dsr
);

  localparam int CW = $clog2(TOK_MAX + 1);
  localparam int GW = $clog2(WR_GAP + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_CMD, S_RESP, S_TOKEN, S_DATA, S_CRC, S_POST, S_DONE
  } state_t;

  typedef enum logic [1:0] {X_LOAD, X_ACC, X_RDY, X_GAP} xfer_t;

  state_t      state_r;
  xfer_t       xfer_r;
  logic [CW-1:0] poll_cnt_r;
  logic [GW-1:0] gap_cnt_r;
  logic [2:0]  byte_idx_r;
  logic [8:0]  data_cnt_r;
  logic [7:0]  rx_r;
  logic [5:0]  cmd_idx_r;
  logic [31:0] cmd_arg_r;
  logic [6:0]  cmd_crc_r;
  logic        read_block_r;
  logic [7:0]  tx_byte_s;

  // Byte to launch for the current state; everything outside the command frame is an idle 0xFF.
  always_comb begin
    tx_byte_s = 8'hFF;
    if (state_r == S_CMD) begin
      case (byte_idx_r)
        3'd0:    tx_byte_s = {2'b01, cmd_idx_r};
        3'd1:    tx_byte_s = cmd_arg_r[31:24];
        3'd2:    tx_byte_s = cmd_arg_r[23:16];
        3'd3:    tx_byte_s = cmd_arg_r[15:8];
        3'd4:    tx_byte_s = cmd_arg_r[7:0];
        3'd5:    tx_byte_s = {cmd_crc_r, 1'b1};
        default: tx_byte_s = 8'hFF;
      endcase
    end else begin
      tx_byte_s = 8'hFF;
    end
  end

  // Main sequencer with embedded byte-transfer handshake; decisions are taken once the write gap ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= S_IDLE;
      xfer_r       <= X_LOAD;
      poll_cnt_r   <= '0;
      gap_cnt_r    <= '0;
      byte_idx_r   <= 3'd0;
      data_cnt_r   <= 9'd0;
      rx_r         <= 8'hFF;
      cmd_idx_r    <= 6'd0;
      cmd_arg_r    <= 32'd0;
      cmd_crc_r    <= 7'd0;
      read_block_r <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      r1           <= 8'hFF;
      err_timeout  <= 1'b0;
      err_token    <= 1'b0;
      rd_data      <= 8'd0;
      rd_valid     <= 1'b0;
      cs_n         <= 1'b1;
      spi_di       <= 8'hFF;
      spi_wr       <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state_r)
        S_IDLE: begin
          // done is still high in the first idle clock, so a coincident start is dropped
          if (start && !done) begin
            cmd_idx_r    <= cmd_idx;
            cmd_arg_r    <= cmd_arg;
            cmd_crc_r    <= cmd_crc;
            read_block_r <= read_block;
            busy         <= 1'b1;
            err_timeout  <= 1'b0;
            err_token    <= 1'b0;
            r1           <= 8'hFF;
            cs_n         <= 1'b0;
            xfer_r       <= X_LOAD;
            state_r      <= S_PRE;
          end
        end
        S_PRE, S_CMD, S_RESP, S_TOKEN, S_DATA, S_CRC, S_POST: begin
          case (xfer_r)
            X_LOAD: begin
              spi_wr <= 1'b1;
              spi_di <= tx_byte_s;
              xfer_r <= X_ACC;
            end
            X_ACC: begin
              if (!spi_dsr) xfer_r <= X_RDY;
            end
            X_RDY: begin
              if (spi_dsr) begin
                rx_r      <= spi_do;
                spi_wr    <= 1'b0;
                gap_cnt_r <= '0;
                xfer_r    <= X_GAP;
              end
            end
            X_GAP: begin
              if (gap_cnt_r == GW'(WR_GAP - 1)) begin
                gap_cnt_r <= '0;
                xfer_r    <= X_LOAD;
                case (state_r)
                  S_PRE: begin
                    byte_idx_r <= 3'd0;
                    state_r    <= S_CMD;
                  end
                  S_CMD: begin
                    if (byte_idx_r == 3'd5) begin
                      poll_cnt_r <= '0;
                      state_r    <= S_RESP;
                    end else begin
                      byte_idx_r <= byte_idx_r + 3'd1;
                    end
                  end
                  S_RESP: begin
                    if (!rx_r[7]) begin
                      r1         <= rx_r;
                      poll_cnt_r <= '0;
                      state_r    <= (read_block_r && rx_r == 8'h00) ? S_TOKEN : S_POST;
                    end else if (poll_cnt_r == CW'(NCR_MAX - 1)) begin
                      err_timeout <= 1'b1;
                      state_r     <= S_POST;
                    end else begin
                      poll_cnt_r <= poll_cnt_r + 1'b1;
                    end
                  end
                  S_TOKEN: begin
                    if (rx_r == 8'hFE) begin
                      data_cnt_r <= 9'd0;
                      state_r    <= S_DATA;
                    end else if (rx_r != 8'hFF) begin
                      err_token <= 1'b1;
                      state_r   <= S_POST;
                    end else if (poll_cnt_r == CW'(TOK_MAX - 1)) begin
                      err_timeout <= 1'b1;
                      state_r     <= S_POST;
                    end else begin
                      poll_cnt_r <= poll_cnt_r + 1'b1;
                    end
                  end
                  S_DATA: begin
                    rd_data    <= rx_r;
                    rd_valid   <= 1'b1;
                    data_cnt_r <= data_cnt_r + 9'd1;
                    if (data_cnt_r == 9'd511) begin
                      byte_idx_r <= 3'd0;
                      state_r    <= S_CRC;
                    end
                  end
                  S_CRC: begin
                    if (byte_idx_r == 3'd1) state_r <= S_POST;
                    else byte_idx_r <= byte_idx_r + 3'd1;
                  end
                  S_POST: begin
                    cs_n    <= 1'b1;
                    state_r <= S_DONE;
                  end
                  default: state_r <= S_IDLE;
                endcase
              end else begin
                gap_cnt_r <= gap_cnt_r + 1'b1;
              end
            end
            default: xfer_r <= X_LOAD;
          endcase
        end
        S_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          spi_wr  <= 1'b0;
          cs_n    <= 1'b1;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Scoreboard bench for sd_cmd_engine: a behavioural SPI host/card returns scripted bytes,
// expected tx bytes and block data are queued up front and compared as the DUT produces them.
module tb_sd_cmd_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  cmd_idx = 6'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic [6:0]  cmd_crc = 7'd0;
  logic        read_block = 1'b0;
  logic        busy, done, err_timeout, err_token, rd_valid, cs_n, spi_wr;
  logic [7:0]  r1, rd_data, spi_di;
  logic [7:0]  spi_do = 8'hFF;
  logic        spi_dsr = 1'b1;

  sd_cmd_engine dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
    .cmd_crc(cmd_crc), .read_block(read_block), .busy(busy), .done(done), .r1(r1),
    .err_timeout(err_timeout), .err_token(err_token), .rd_data(rd_data), .rd_valid(rd_valid),
    .cs_n(cs_n), .spi_di(spi_di), .spi_wr(spi_wr), .spi_do(spi_do), .spi_dsr(spi_dsr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rd[$];
  int tx_seen, rd_seen, done_seen, min_gap, low_cnt;
  bit first_byte;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SPI host + card model and output monitor, all on the falling edge
  initial begin
    int hst;
    int dly;
    logic [7:0] e;
    hst = 0;
    dly = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hst = 0;
        spi_dsr = 1'b1;
        low_cnt = 0;
      end else begin
        if (rd_valid) begin
          rd_seen++;
          if (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            check("rd_data", rd_data, e);
          end
        end
        if (done) done_seen++;
        if (busy && !spi_wr) low_cnt++;
        case (hst)
          0: if (spi_wr) begin
            tx_seen++;
            if (!first_byte && low_cnt < min_gap) min_gap = low_cnt;
            first_byte = 1'b0;
            low_cnt = 0;
            if (exp_tx.size() > 0) begin
              e = exp_tx.pop_front();
              check("tx_byte", spi_di, e);
            end
            spi_dsr = 1'b0;
            dly = 3;
            hst = 1;
          end
          1: begin
            dly--;
            if (dly == 0) begin
              spi_do = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hFF;
              spi_dsr = 1'b1;
              hst = 2;
            end
          end
          default: if (!spi_wr) hst = 0;
        endcase
      end
    end
  end

  task automatic prep();
    rx_q.delete();
    exp_tx.delete();
    exp_rd.delete();
    tx_seen = 0;
    rd_seen = 0;
    done_seen = 0;
    min_gap = 1000;
    low_cnt = 0;
    first_byte = 1'b1;
  endtask

  task automatic push_rx_ff(input int n);
    for (int i = 0; i < n; i++) rx_q.push_back(8'hFF);
  endtask

  task automatic push_tx_ff(input int n);
    for (int i = 0; i < n; i++) exp_tx.push_back(8'hFF);
  endtask

  task automatic push_cmd_tx(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc);
    exp_tx.push_back(8'hFF);
    exp_tx.push_back({2'b01, idx});
    exp_tx.push_back(arg[31:24]);
    exp_tx.push_back(arg[23:16]);
    exp_tx.push_back(arg[15:8]);
    exp_tx.push_back(arg[7:0]);
    exp_tx.push_back({crc, 1'b1});
  endtask

  task automatic kick(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc, input logic rb);
    @(negedge clk);
    cmd_idx = idx;
    cmd_arg = arg;
    cmd_crc = crc;
    read_block = rb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("cs_low_after_start", cs_n, 1'b0);
  endtask

  task automatic run(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                     input logic rb, input bit ovl, input logic [7:0] r1_exp, input bit eto,
                     input bit etk, input int ntx, input int nrd);
    kick(idx, arg, crc, rb);
    for (int i = 0; i < 40000 && done_seen == 0; i++) begin
      @(negedge clk);
      if (ovl) begin
        if (i == 50) begin
          start = 1'b1;
          cmd_idx = 6'd55;
          cmd_arg = 32'hFFFF_FFFF;
          cmd_crc = 7'd0;
          read_block = 1'b1;
        end else if (done) begin
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
    end
    check("done_reached", done_seen, 1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("single_done", done_seen, 1);
    check("busy_idle", busy, 1'b0);
    check("cs_high_end", cs_n, 1'b1);
    check("r1", r1, r1_exp);
    check("err_timeout", err_timeout, eto);
    check("err_token", err_token, etk);
    check("tx_count", tx_seen, ntx);
    check("rd_count", rd_seen, nrd);
    check("tx_queue_empty", exp_tx.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);
    check("wr_gap_min", (min_gap >= 16) ? 1 : 0, 1);
  endtask

  task automatic block_rx_script(input logic [7:0] crc_a, input logic [7:0] crc_b);
    push_rx_ff(7);
    rx_q.push_back(8'hFF);
    rx_q.push_back(8'h00);
    push_rx_ff(3);
    rx_q.push_back(8'hFE);
    for (int i = 0; i < 512; i++) rx_q.push_back(i[7:0]);
    rx_q.push_back(crc_a);
    rx_q.push_back(crc_b);
  endtask

  task automatic cmd0_scenario();
    prep();
    push_rx_ff(9);
    rx_q.push_back(8'h01);
    push_cmd_tx(6'd0, 32'd0, 7'h4A);
    push_tx_ff(4);
    run(6'd0, 32'd0, 7'h4A, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 11, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_r1", r1, 8'hFF);
    check("rst_errs", {err_timeout, err_token}, 2'b00);
    check("rst_rd", {rd_valid, rd_data}, 9'd0);
    check("rst_cs", cs_n, 1'b1);
    check("rst_spi", {spi_wr, spi_di}, 9'h0FF);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // CMD0, R1=01 after two idle bytes
    cmd0_scenario();

    // no response: 1 + 6 + 8 + 1 transfers
    prep();
    push_cmd_tx(6'd8, 32'h0000_01AA, 7'h43);
    push_tx_ff(9);
    run(6'd8, 32'h0000_01AA, 7'h43, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 16, 0);

    // CMD17 full block read
    prep();
    block_rx_script(8'hAB, 8'hCD);
    push_cmd_tx(6'd17, 32'h0000_0200, 7'h7F);
    push_tx_ff(2 + 4 + 512 + 2 + 1);
    for (int i = 0; i < 512; i++) exp_rd.push_back(i[7:0]);
    run(6'd17, 32'h0000_0200, 7'h7F, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 528, 512);

    // CMD17 with data-error token
    prep();
    push_rx_ff(7);
    rx_q.push_back(8'h00);
    rx_q.push_back(8'h05);
    push_cmd_tx(6'd17, 32'h1234_5678, 7'h2C);
    push_tx_ff(3);
    run(6'd17, 32'h1234_5678, 7'h2C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 10, 0);

    // reset in the middle of the data phase, then a clean CMD0
    prep();
    block_rx_script(8'h00, 8'h00);
    kick(6'd17, 32'h0000_0000, 7'h00, 1'b1);
    for (int i = 0; i < 20000 && rd_seen < 100; i++) @(negedge clk);
    check("reach_data_byte100", (rd_seen >= 100) ? 1 : 0, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_cs", cs_n, 1'b1);
    check("midrst_wr", spi_wr, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rdv", rd_valid, 1'b0);
    check("midrst_r1", r1, 8'hFF);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    cmd0_scenario();

    // start during busy and start coincident with done are both ignored
    prep();
    push_rx_ff(8);
    rx_q.push_back(8'h01);
    push_cmd_tx(6'd8, 32'h0000_01AA, 7'h43);
    push_tx_ff(3);
    run(6'd8, 32'h0000_01AA, 7'h43, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
